apb_master_queued: RTL and testbench
====================================

Name: apb_master_queued

Overview:
Parameterised APB4 master that succeeds the single-transfer master. It accepts requests from higher logic through a valid/ready port into a request FIFO, and issues back-to-back APB transfers without returning to IDLE. It binary-decodes the slave index from the address MSBs into a one-hot PSEL, and reports per-transfer completion with read data, slave error, decode error and timeout status. It sits between the system-level request logic and the APB slave bank.

Parameters:
DATA_WIDTH, 32, PWDATA/PRDATA width; must be a multiple of 8; STRB_W = DATA_WIDTH/8 (localparam).
ADDR_WIDTH, 32, request and PADDR width.
SLAVE_NUM, 4, number of PSEL lines (>=2); SEL_W = clog2(SLAVE_NUM) (localparam).
FIFO_DEPTH, 4, request FIFO entries; power of two, >=2.
TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for PREADY before abort; >=1.

Ports:
PCLK  in  1  system clock
PRESET_n  in  1  asynchronous active-low reset
req_valid  in  1  request offered
req_ready  out  1  FIFO not full; a request is accepted when req_valid&&req_ready
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  {slave index in top SEL_W bits, register byte address}
req_wdata  in  DATA_WIDTH  write data
req_strb  in  STRB_W  write byte strobes
rsp_valid  out  1  single-cycle completion pulse; no backpressure
rsp_rdata  out  DATA_WIDTH  PRDATA captured on read completion, else 0
rsp_err  out  1  PSLVERR, decode error or timeout
rsp_timeout  out  1  completion was a timeout abort
busy  out  1  FIFO non-empty or FSM not IDLE
PADDR  out  ADDR_WIDTH  full request address
PSEL  out  SLAVE_NUM  one-hot slave select
PENABLE  out  1  access phase
PWRITE  out  1  direction
PWDATA  out  DATA_WIDTH  write data; 0 for reads
PSTRB  out  STRB_W  strobes; 0 for reads
PREADY  in  1  slave ready
PRDATA  in  DATA_WIDTH  slave read data
PSLVERR  in  1  slave error, sampled with PREADY

Behaviour:
- Reset (asynchronous, PRESET_n low): all outputs 0 except req_ready=1. FIFO is flushed, FSM goes to IDLE, timeout counter is cleared. A transfer in flight is dropped with no response.
- FIFO: push on req_valid&&req_ready. req_ready = !full. When full, no push occurs even if a pop happens in the same cycle. Pointers wrap modulo FIFO_DEPTH; the count has one extra bit.
- Decode: idx = req_addr[ADDR_WIDTH-1 -: SEL_W]. If idx < SLAVE_NUM, PSEL = 1<<idx. Otherwise it is a decode error.
- FSM states: IDLE, SETUP, ACCESS, DERR. All APB outputs are registered.
- IDLE: if FIFO non-empty, pop the head and go to SETUP (valid idx) or DERR (invalid idx). APB outputs stay 0 in IDLE.
- SETUP: PSEL/PADDR/PWRITE/PWDATA/PSTRB are driven from the popped entry with PENABLE=0. Always goes to ACCESS next cycle.
- ACCESS: PENABLE=1 and all other APB outputs are held stable. The timeout counter increments each cycle PREADY=0.
  - On PREADY=1: complete the transfer. Next state is SETUP if the FIFO is non-empty (popping in that cycle), else IDLE.
  - If the counter reaches TIMEOUT_CYCLES with PREADY=0: abort, drive PSEL/PENABLE to 0 next cycle, and go to IDLE.
- DERR: no APB activity (PSEL=0). Lasts one cycle, then goes to IDLE.
- Response: registered and asserted the cycle after completion, i.e. the cycle after ACCESS&&PREADY, the timeout abort, or DERR.
  - rsp_err = PSLVERR | decode error | timeout.
  - rsp_rdata = PRDATA only for a successful read, else 0.
  - rsp_timeout = 1 only on abort.
  - All rsp_* outputs are 0 when rsp_valid=0.
- Latency: a request pushed at cycle 0 into an empty, idle block gives SETUP at cycle 2 and ACCESS at cycle 3. With zero-wait PREADY, rsp_valid is high at cycle 4.
- Back-to-back: steady-state throughput is one transfer per 2 cycles with zero-wait slaves.
- Timeout counter clears on every entry to SETUP.

Decomposition:
- Package apb_pkg: state encoding localparams, clog2 function, response-status bit positions.
- Sub-module apb_req_fifo: parameterised synchronous FIFO holding {write, addr, wdata, strb}, with push/pop/full/empty/count ports and the same asynchronous reset.

Test Plan:
- Zero-wait write: push addr 0x4000_0010, wdata 0xDEAD_BEEF, strb 4'hF -> PSEL=4'b0010, PSTRB=4'hF in SETUP(c2) and ACCESS(c3); rsp_valid at c4 with rsp_err=0.
- Wait-state read: PREADY low for 3 ACCESS cycles, then PRDATA=0x1234_5678 -> ACCESS outputs stable for 4 cycles; rsp_rdata=0x1234_5678, PSTRB=0, PWDATA=0.
- Back-to-back: 5 pushes with FIFO_DEPTH=4 and a slow slave -> req_ready drops after 4 accepted (plus the one popped). ACCESS goes straight to SETUP with no IDLE cycle; 5 responses arrive in order.
- Decode error with SLAVE_NUM=3: addr 0xC000_0000 -> PSEL stays 0, DERR state; rsp_valid with rsp_err=1, rsp_timeout=0.
- Timeout and PSLVERR: PREADY held 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1. Next transfer with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
- Reset mid-ACCESS with 2 queued requests: PRESET_n low -> outputs 0 immediately, busy=0, no rsp_valid after release.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state type, response status layout and clog2 helper for the queued APB master
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DERR   = 2'd3
  } apb_state_t;

  localparam int RSP_ERR_BIT = 0;
  localparam int RSP_TO_BIT  = 1;
  localparam int RSP_STAT_W  = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/apb_req_fifo.sv
// rtl/apb_req_fifo.sv - synchronous request FIFO with occupancy count and asynchronous flush
module apb_req_fifo
  import apb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_master_queued.sv
// rtl/apb_master_queued.sv - queued APB4 master with slave decode, timeout abort and per-transfer status
module apb_master_queued
  import apb_pkg::*;
#(
  parameter int  DATA_WIDTH     = 32,
  parameter int  ADDR_WIDTH     = 32,
  parameter int  SLAVE_NUM      = 4,
  parameter int  FIFO_DEPTH     = 4,
  parameter int  TIMEOUT_CYCLES = 16,
  localparam int STRB_W         = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_W-1:0]     req_strb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [SLAVE_NUM-1:0]  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_W-1:0]     PSTRB,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int SEL_W = clog2(SLAVE_NUM);
  localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;
  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
  localparam int TO_W  = clog2(TIMEOUT_CYCLES + 1);

  apb_state_t            state, state_n;
  logic [ENT_W-1:0]      head;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [STRB_W-1:0]     head_strb;
  logic [SEL_W-1:0]      head_idx;
  logic                  head_ok;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  pop, load, done, abort;
  logic [TO_W-1:0]       to_cnt;
  logic [RSP_STAT_W-1:0] rsp_stat;

  apb_req_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESET_n),
    .push  (req_valid),
    .din   ({req_write, req_addr, req_wdata, req_strb}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_write, head_addr, head_wdata, head_strb} = head;
  assign head_idx  = head_addr[ADDR_WIDTH-1 -: SEL_W];
  assign head_ok   = (32'(head_idx) < SLAVE_NUM);
  assign req_ready = !fifo_full;
  assign busy      = (fifo_count != '0) || (state != ST_IDLE);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = head_ok;
          state_n = head_ok ? ST_SETUP : ST_DERR;
        end
      end
      ST_SETUP: state_n = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          done = 1'b1;
          // Chain straight into the next transfer so the bus never idles between queued requests.
          if (!fifo_empty) begin
            pop     = 1'b1;
            load    = head_ok;
            state_n = head_ok ? ST_SETUP : ST_DERR;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          abort   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_DERR: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) state <= ST_IDLE;
    else           state <= state_n;
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      PSEL    <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      PENABLE <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (load) begin
        PSEL    <= SLAVE_NUM'(1) << head_idx;
        PADDR   <= head_addr;
        PWRITE  <= head_write;
        PWDATA  <= head_write ? head_wdata : '0;
        PSTRB   <= head_write ? head_strb : '0;
        PENABLE <= 1'b0;
      end else if (state_n == ST_ACCESS) begin
        PENABLE <= 1'b1;
      end else begin
        PSEL    <= '0;
        PADDR   <= '0;
        PWRITE  <= 1'b0;
        PWDATA  <= '0;
        PSTRB   <= '0;
        PENABLE <= 1'b0;
      end
      if (load)                             to_cnt <= '0;
      else if (state == ST_ACCESS && !PREADY) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_stat  <= '0;
    end else begin
      rsp_valid              <= done || abort || (state == ST_DERR);
      rsp_rdata              <= (done && !PWRITE && !PSLVERR) ? PRDATA : '0;
      rsp_stat[RSP_ERR_BIT]  <= (done && PSLVERR) || abort || (state == ST_DERR);
      rsp_stat[RSP_TO_BIT]   <= abort;
    end
  end

  assign rsp_err     = rsp_stat[RSP_ERR_BIT];
  assign rsp_timeout = rsp_stat[RSP_TO_BIT];

endmodule

// File: tb/tb_apb_master_queued.sv
// tb/tb_apb_master_queued.sv - scoreboard bench for apb_master_queued with a behavioural slave and response model
module tb_apb_master_queued;

  localparam int SN = 3;
  localparam int TO = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wt;
    logic [31:0] prdata;
    logic        slverr;
  } xfer_t;

  logic        PCLK = 1'b0;
  logic        PRESET_n = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [SN-1:0] PSEL;
  logic        PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]  PSTRB;

  rsp_t  exp_q[$];
  xfer_t slv_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_done = -10;
  bit    btb_mode = 1'b0;
  bit    btb_first = 1'b0;

  apb_master_queued #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SLAVE_NUM(SN), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial forever #5 PCLK = ~PCLK;
  initial forever begin @(posedge PCLK); cyc++; end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or never seen (cycle %0d)", name, cyc);
  endtask

  function automatic logic [SN-1:0] exp_sel(input logic [31:0] a);
    logic [SN-1:0] one;
    one = 1;
    return one << a[31:30];
  endfunction

  task automatic check_fields(input string tag, input xfer_t x);
    chk({tag, "_ctrl"}, {PSEL, PWRITE, PSTRB, PADDR},
        {exp_sel(x.addr), x.write, x.write ? x.strb : 4'h0, x.addr});
    chk({tag, "_wdata"}, PWDATA, x.write ? x.wdata : 32'h0);
  endtask

  // Behavioural slave: each accepted transfer carries its own wait count, read data and error.
  initial begin
    xfer_t cur;
    int    acc_k;
    bit    in_acc, acc_done;
    cur = '{default: '0};
    acc_k = 0; in_acc = 0; acc_done = 0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(posedge PCLK); #2;
      if (!PRESET_n) begin
        in_acc = 0;
        PREADY = 1'b0;
        continue;
      end
      if (in_acc && !(PSEL != 0 && PENABLE)) begin
        if (!acc_done) chk("timeout_len", acc_k, TO);
        in_acc = 0;
      end
      if (PSEL != 0 && !PENABLE) begin
        if (slv_q.size() == 0) fail("setup_unexpected");
        else begin
          cur = slv_q.pop_front();
          check_fields("setup", cur);
          if (btb_mode) begin
            if (!btb_first) chk("btb_gap", cyc - last_done, 1);
            btb_first = 0;
          end
        end
        acc_k = 0; acc_done = 0;
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      end else if (PSEL != 0 && PENABLE) begin
        in_acc = 1;
        acc_k++;
        check_fields("access_hold", cur);
        if (acc_k > TO) chk("access_overrun", acc_k, TO);
        if (acc_k > cur.wt) begin
          PREADY = 1'b1; PRDATA = cur.prdata; PSLVERR = cur.slverr;
          acc_done = 1; last_done = cyc;
        end else begin
          PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        end
      end else begin
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a completion is presented.
  initial begin
    rsp_t e;
    forever begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) fail("rsp_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("rsp", {rsp_rdata, rsp_err, rsp_timeout}, {e.rdata, e.err, e.to});
        end
      end else begin
        chk("rsp_idle_zero", {rsp_rdata, rsp_err, rsp_timeout}, 34'd0);
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int wt, input logic [31:0] prd, input logic se);
    int    n;
    xfer_t x;
    rsp_t  e;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
    forever begin
      @(negedge PCLK);
      if (req_ready) break;
      n++;
      if (n > 500) begin
        $display("FAIL req_ready_stuck: request never accepted (cycle %0d)", cyc);
        $fatal(1);
      end
    end
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    x = '{write: w, addr: a, wdata: d, strb: s, wt: wt, prdata: prd, slverr: se};
    if (int'(a[31:30]) >= SN) e = '{rdata: 32'h0, err: 1'b1, to: 1'b0};
    else begin
      slv_q.push_back(x);
      if (wt >= TO) e = '{rdata: 32'h0, err: 1'b1, to: 1'b1};
      else          e = '{rdata: (!w && !se) ? prd : 32'h0, err: se, to: 1'b0};
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_rsp(output int n, output logic [SN-1:0] psel_seen);
    n = 0;
    psel_seen = '0;
    do begin
      @(negedge PCLK);
      n++;
      psel_seen |= PSEL;
    end while (rsp_valid !== 1'b1 && n < 200);
    if (rsp_valid !== 1'b1) fail("rsp_wait");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge PCLK);
      n++;
    end
    if (exp_q.size() != 0 || busy) fail("drain");
    @(posedge PCLK); #1;
  endtask

  initial begin
    int            n, c0, r, wt;
    logic [SN-1:0] ps;
    logic [1:0]    idx;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0;

    #12;
    chk("reset_ctrl", {rsp_valid, busy, PSEL, PENABLE, PWRITE, PSTRB, rsp_err, rsp_timeout}, 0);
    chk("reset_buses", {PADDR, PWDATA}, 0);
    chk("reset_req_ready", req_ready, 1);
    @(negedge PCLK); PRESET_n = 1'b1;
    @(posedge PCLK); #1;

    issue(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    @(negedge PCLK); chk("c1_idle", {PSEL, busy}, {3'b000, 1'b1});
    @(negedge PCLK); chk("c2_setup", {PSEL, PENABLE, PSTRB}, {3'b010, 1'b0, 4'hF});
    @(negedge PCLK); chk("c3_access", {PSEL, PENABLE}, {3'b010, 1'b1});
    @(negedge PCLK); chk("c4_rsp_valid", rsp_valid, 1);
    drain();

    issue(1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 3, 32'h1234_5678, 1'b0);
    wait_rsp(n, ps); chk("read_wait_latency", n, 7);
    drain();

    issue(1'b0, 32'hC000_0000, 32'h0, 4'h0, 0, 32'h5555_5555, 1'b0);
    wait_rsp(n, ps); chk("derr_latency", n, 3); chk("derr_psel", ps, 0);
    drain();

    issue(1'b0, 32'h8000_0004, 32'h0, 4'h0, 100, 32'h0, 1'b0);
    wait_rsp(n, ps); chk("timeout_latency", n, 19);
    drain();
    issue(1'b1, 32'h4000_0100, 32'hCAFE_F00D, 4'h3, 0, 32'h0, 1'b1);
    wait_rsp(n, ps); chk("slverr_latency", n, 4);
    drain();

    btb_mode = 1; btb_first = 1;
    c0 = cyc;
    for (int i = 0; i < 5; i++)
      issue(1'(i), {2'(i % 3), 30'(i * 16)}, $urandom, 4'(i + 1), 6, $urandom, 1'b0);
    chk("btb_accept_cycles", cyc - c0, 5);
    @(negedge PCLK); chk("btb_full_req_ready", req_ready, 0);
    drain();
    btb_first = 1;
    for (int i = 0; i < 6; i++)
      issue(1'($urandom), {2'(i % 3), 30'($urandom)}, $urandom, 4'($urandom), 0, $urandom, 1'b0);
    drain();
    btb_mode = 0;

    for (int i = 0; i < 80; i++) begin
      idx = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 19));
      wt = (r < 14) ? r % 4 : (r < 17) ? 15 : (r < 19) ? 16 : 25;
      issue(1'($urandom), {idx, 30'($urandom)}, $urandom, 4'($urandom), wt, $urandom,
            $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 4)) begin @(posedge PCLK); #1; end
    end
    drain();

    for (int i = 0; i < 3; i++)
      issue(1'b1, {2'(i), 30'h100}, $urandom, 4'hF, 10, 32'h0, 1'b0);
    n = 0;
    do begin @(negedge PCLK); n++; end while (!(PSEL != 0 && PENABLE) && n < 50);
    if (!(PSEL != 0 && PENABLE)) fail("reset_access_wait");
    #2 PRESET_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {PSEL, PENABLE, PWRITE, PSTRB, busy, rsp_valid}, 0);
    chk("rst_mid_buses", {PADDR, PWDATA}, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    exp_q.delete();
    slv_q.delete();
    repeat (2) @(negedge PCLK);
    PRESET_n = 1'b1;
    ps = '0;
    r = 0;
    repeat (20) begin
      @(negedge PCLK);
      ps |= PSEL;
      r += int'(busy);
    end
    chk("post_reset_quiet", {ps, 32'(r)}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
